// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if -- operand/result handshake bundle for cla_pipe_adder.
// The master side (producer/consumer bench or parent) drives operands and
// out_ready; the slave side (the adder) drives in_ready and the result beat.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;

  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- pipelined carry-lookahead adder/subtractor.
// WIDTH/GROUP stages; stage k resolves bits [k*GROUP +: GROUP] with a flat
// sum-of-products lookahead over its group, registers those sum bits, its
// group carry-out and the operand bits still to be consumed. A single global
// stall (in_ready = !out_valid | out_ready) freezes every stage together.
// Optional build macro CLA_PIPE_SAT_EN: on signed overflow the sum saturates
// to the signed limit instead of wrapping; ovf is still reported and zero is
// taken from the saturated value.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  bus
);

  localparam int S = WIDTH / GROUP;

  logic advance;  // whole pipe moves one stage this cycle
  logic out_v;    // valid bit of the final stage

  // Group carries c[0..GROUP] from generate/propagate and the group carry-in.
  // Every c[i+1] is an independent sum of products, so no carry ripples
  // through the group: term j is ge[j] propagated through p[j..i], where
  // ge[0] is the carry-in and ge[j] = g[j-1] for j >= 1.
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             c0
  );
    logic [GROUP:0] ge;
    logic [GROUP:0] c;
    logic           acc;
    logic           term;
    // NOTE: blocking is correct here; these are combinational temporaries
    // evaluated in order within one call, not state.
    ge   = {g, c0};
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i + 1; j++) begin
        term = ge[j];
        for (int m = j; m <= i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  assign advance      = !out_v || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int AW  = WIDTH - k * GROUP;        // operand bits entering stage k
    localparam int REM = WIDTH - (k + 1) * GROUP;  // operand bits left after stage k

    logic                     v_in;
    logic                     c_in;
    logic [AW-1:0]            a_in;
    logic [AW-1:0]            b_in;
    logic [(k+1)*GROUP-1:0]   psum_d;   // sum bits resolved so far, incl. this group
    logic [GROUP-1:0]         g;
    logic [GROUP-1:0]         p;
    logic [GROUP:0]           c;
    logic [GROUP-1:0]         s;

    // Stage inputs: the interface for stage 0 (with subtract folded into b
    // and the carry-in), otherwise the previous stage's registers.
    if (k == 0) begin : g_in
      assign v_in   = bus.in_valid;
      assign c_in   = bus.op_sub | bus.cin;
      assign a_in   = bus.a;
      assign b_in   = bus.op_sub ? ~bus.b : bus.b;
      assign psum_d = s;
    end else begin : g_in
      assign v_in   = g_stage[k-1].g_mid.v_q;
      assign c_in   = g_stage[k-1].g_mid.c_q;
      assign a_in   = g_stage[k-1].g_mid.a_q;
      assign b_in   = g_stage[k-1].g_mid.b_q;
      assign psum_d = {s, g_stage[k-1].g_mid.psum_q};
    end

    assign g = a_in[GROUP-1:0] & b_in[GROUP-1:0];
    assign p = a_in[GROUP-1:0] ^ b_in[GROUP-1:0];
    assign c = cla_carries(g, p, c_in);
    assign s = p ^ c[GROUP-1:0];

    if (k < S - 1) begin : g_mid
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*GROUP-1:0] psum_q;
      logic [REM-1:0]         a_q;
      logic [REM-1:0]         b_q;

      // Intermediate stage: capture group result and the unconsumed operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q    <= 1'b0;
          c_q    <= 1'b0;
          psum_q <= '0;
          a_q    <= '0;
          b_q    <= '0;
        end else if (advance) begin
          // NOTE: non-blocking so every stage samples its neighbour's value
          // from before the edge; blocking here would collapse the pipe.
          v_q    <= v_in;
          c_q    <= c[GROUP];
          psum_q <= psum_d;
          a_q    <= a_in[AW-1:GROUP];
          b_q    <= b_in[AW-1:GROUP];
        end
      end
    end else begin : g_last
      logic             ovf_w;
      logic [WIDTH-1:0] res;
      logic             v_q;
      logic             cout_q;
      logic             ovf_q;
      logic             zero_q;
      logic [WIDTH-1:0] sum_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      assign ovf_w = c[GROUP] ^ c[GROUP-1];

`ifdef CLA_PIPE_SAT_EN
      // On overflow both operands share a sign, and that sign (the MSB of a)
      // is the sign of the true result: clamp towards it.
      assign res = ovf_w ? {a_in[GROUP-1], {(WIDTH-1){~a_in[GROUP-1]}}} : psum_d;
`else
      assign res = psum_d;
`endif

      // Final stage: register the complete result beat and its flags.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q    <= 1'b0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          sum_q  <= '0;
        end else if (advance) begin
          v_q    <= v_in;
          cout_q <= c[GROUP];
          ovf_q  <= ovf_w;
          zero_q <= (res == '0);
          sum_q  <= res;
        end
      end

      assign out_v         = v_q;
      assign bus.out_valid = v_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = cout_q;
      assign bus.ovf       = ovf_q;
      assign bus.zero      = zero_q;
    end
  end

endmodule
